// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the convolution sequencer: fixed-point word
//   defaults, FSM state encoding and the tap-index width helper.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

   // Default fixed-point format: N-bit two's-complement word, Q fraction bits
   localparam int unsigned Q_DEF = 16;
   localparam int unsigned N_DEF = 32;

   // Sequencer states
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_FLUSH = 3'd2,
      S_ADD   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Width of a tap index 0..k-1, never narrower than one bit
   function automatic int tap_w(input int k);
      return (k <= 1) ? 1 : $clog2(k);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fma.sv
// ----------------------------------------------------------------------------
// fma
//   Fixed-point fused multiply-add: y = acc + (a * b) >> Q, N-bit
//   two's-complement operands, result wraps to N bits (no saturation,
//   truncating product scaling).
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fma #(
   parameter int unsigned Q = 16,
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] acc_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] y_o
);

   // Full-width signed product; sign extension keeps the low 2N bits exact
   logic [2*N-1:0] prod_w;

   assign prod_w = {{N{a_i[N-1]}}, a_i} * {{N{b_i[N-1]}}, b_i};
   assign y_o    = acc_i + N'(prod_w >> Q);

endmodule

`default_nettype wire

// File: rtl/qadd.sv
// ----------------------------------------------------------------------------
// qadd
//   Fixed-point add of two N-bit two's-complement words; result wraps.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qadd #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] y_o
);

   assign y_o = a_i + b_i;

endmodule

`default_nettype wire

// File: rtl/conv_seq.sv
// ----------------------------------------------------------------------------
// conv_seq
//   Sequential convolution pixel engine. One start computes a single output
//   pixel by walking K = SIZE*SIZE taps through one shared fma, then adding
//   the bias with qadd. Result latency is K+2 cycles from start acceptance.
//   Optional macro CONV_SEQ_RELU_EN: clamp negative results to zero.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module conv_seq
   import conv_pkg::*;
#(
   parameter int unsigned SIZE = 7,
   parameter int unsigned Q    = Q_DEF,
   parameter int unsigned N    = N_DEF
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start_valid,
   output logic                              start_ready,
   input  logic [N-1:0]                      bias,
   output logic                              rd_en,
   output logic [tap_w(SIZE*SIZE)-1:0]       rd_addr,
   input  logic [N-1:0]                      filt_data,
   input  logic [N-1:0]                      act_data,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic [N-1:0]                      res_data,
   output logic                              busy
);

   localparam int unsigned K  = SIZE * SIZE;
   localparam int unsigned AW = tap_w(K);
   localparam logic [AW-1:0] LAST_TAP = AW'(K - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q,   cnt_d;
   logic [N-1:0]  acc_q,   acc_d;
   logic [N-1:0]  bias_q,  bias_d;
   logic [N-1:0]  res_q,   res_d;
   logic          rdv_q,   rdv_d;   // rd_en delayed by one: tap data is valid
   logic [N-1:0]  fma_y;
   logic [N-1:0]  sum_y;

   fma #(.Q(Q), .N(N)) u_fma (
      .acc_i (acc_q),
      .a_i   (filt_data),
      .b_i   (act_data),
      .y_o   (fma_y)
   );

   qadd #(.N(N)) u_qadd (
      .a_i   (acc_q),
      .b_i   (bias_q),
      .y_o   (sum_y)
   );

   // Moore outputs decoded from the state register
   assign start_ready = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign rd_en       = (state_q == S_RUN);
   assign rd_addr     = rd_en ? cnt_q : '0;
   assign res_valid   = (state_q == S_DONE);
   assign res_data    = res_q;

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      bias_d  = bias_q;
      res_d   = res_q;
      rdv_d   = (state_q == S_RUN);

      // Tap data returned for the previous cycle's read is folded in here;
      // this also covers the last tap, which arrives during FLUSH.
      if (rdv_q) begin
         acc_d = fma_y;
      end

      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               state_d = S_RUN;
               acc_d   = '0;
               bias_d  = bias;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (cnt_q == LAST_TAP) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + AW'(1);
            end
         end
         S_FLUSH: begin
            state_d = S_ADD;
         end
         S_ADD: begin
`ifdef CONV_SEQ_RELU_EN
            res_d   = sum_y[N-1] ? '0 : sum_y;
`else
            res_d   = sum_y;
`endif
            state_d = S_DONE;
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         bias_q  <= '0;
         res_q   <= '0;
         rdv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         bias_q  <= bias_d;
         res_q   <= res_d;
         rdv_q   <= rdv_d;
      end
   end

endmodule

`default_nettype wire

// File: doc/conv_seq.md
CONV_SEQ -- requirements
Module: conv_seq

Interface
REQ-001 Parameter SIZE, default 7, kernel edge; K = SIZE*SIZE taps per window.
REQ-002 Parameter Q, default 16, fractional bits of the fixed-point word.
REQ-003 Parameter N, default 32, word width.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port start_valid  in  1  request to compute one output pixel.
REQ-007 Port start_ready  out  1  high only in IDLE; start accepted on start_valid & start_ready.
REQ-008 Port bias  in  N  bias word, sampled at start acceptance.
REQ-009 Port rd_en  out  1  tap read strobe to filter/activation buffers.
REQ-010 Port rd_addr  out  $clog2(K) (min 1)  tap index 0..K-1.
REQ-011 Port filt_data  in  N  filter tap, valid the cycle after its rd_en.
REQ-012 Port act_data  in  N  activation tap, valid the cycle after its rd_en.
REQ-013 Port res_valid  out  1  result available.
REQ-014 Port res_ready  in  1  consumer accepts; handshake = res_valid & res_ready.
REQ-015 Port res_data  out  N  output pixel.
REQ-016 Port busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, RUN, FLUSH, ADD, DONE; block SHALL time-multiplex one fma instance over K taps.
REQ-018 IDLE->RUN on start acceptance; accumulator cleared to 0, bias registered, tap counter = 0.
REQ-019 RUN: rd_en=1, rd_addr = counter, counter increments each cycle; after addr K-1 issued -> FLUSH.
REQ-020 A one-cycle-delayed copy of rd_en SHALL qualify accumulation: acc <= fma(acc, filt_data, act_data) only when set.
REQ-021 FLUSH: rd_en=0, absorbs final tap; -> ADD.
REQ-022 ADD: res_data <= qadd(acc, bias_reg); -> DONE.
REQ-023 DONE: res_valid=1, res_data held stable until handshake; on handshake -> IDLE in same edge.
REQ-024 Latency: res_valid rises exactly K+2 cycles after the start-acceptance edge (51 for SIZE=7).
REQ-025 start_valid outside IDLE SHALL be ignored, no queuing; new start earliest the cycle after result handshake.
REQ-026 res_ready held low SHALL stall indefinitely in DONE with no state or output change.
REQ-027 Arithmetic SHALL be the team's Q.(Q) N-bit format exactly as produced by fma/qadd; no extra rounding or widening.
REQ-028 SIZE=1 SHALL work (K=1, one RUN cycle, latency 3).
REQ-029 rd_addr SHALL read 0 whenever rd_en=0.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, acc=0, counter=0, bias_reg=0, res_data=0, res_valid=0, rd_en=0, busy=0, delayed-valid=0.
REQ-031 Reset mid-operation SHALL abort the window; no partial result emitted after release.

Configuration
REQ-032 Macro CONV_SEQ_RELU_EN: defined -> ADD stage stores 0 when qadd result is negative (sign bit set), else result; undefined -> raw qadd result.

Structure
REQ-033 Shared package conv_pkg: Q/N defaults, FSM state enum, tap-index width function.
REQ-034 Existing fma and qadd cells instantiated once each; no new sub-module.

Verification
REQ-035 All filt/act = 0x00010000 (1.0), bias 0, SIZE=7 -> res_data 0x00310000 (49.0), res_valid at cycle 51.
REQ-036 filt=0x00008000 (0.5), act=0x00020000 (2.0), bias 0x00010000 -> res_data 0x00320000 (50.0).
REQ-037 res_ready low 10 cycles after res_valid -> res_data/res_valid stable, start_ready=0 throughout; handshake -> IDLE next cycle.
REQ-038 start_valid pulsed at cycle 20 of RUN -> ignored, single result, rd_addr sequence 0..48 uninterrupted.
REQ-039 rst_n low at tap 30 then new start -> result equals clean-run value, no spurious res_valid.
REQ-040 CONV_SEQ_RELU_EN defined, all taps 0, bias = -1.0 -> res_data 0; undefined -> res_data = -1.0 encoding.
